next_pc_unit: RTL and testbench

//  Program-flow stage next to the jump/branch decode: holds the PC and the 2-bit status register.

---
 rtl/flow_pkg.sv | 20 ++
 rtl/next_pc_unit_if.sv | 13 +
 rtl/next_pc_calc.sv | 44 ++++
 rtl/next_pc_unit.sv | 137 +++++++++++++
 tb/tb_next_pc_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/flow_pkg.sv
// Shared encodings for the program-flow stage: next-PC selects, FSM states
// and status register bit positions.
package flow_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] SEL_SEQ = 2'b00;
   localparam logic [1:0] SEL_JMP = 2'b01;
   localparam logic [1:0] SEL_JM  = 2'b10;
   localparam logic [1:0] SEL_BR  = 2'b11;

   localparam int unsigned STAT_Z = 1;
   localparam int unsigned STAT_N = 0;

   typedef enum logic {
      IDLE    = 1'b0,
      JM_WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/next_pc_unit_if.sv
// Data-memory read handshake used by the memory-indirect jump.
interface next_pc_unit_if;
   import flow_pkg::*;

   logic            dmem_req;
   logic [XLEN-1:0] dmem_addr;
   logic            dmem_ack;
   logic [XLEN-1:0] dmem_rdata;

   modport master (output dmem_req, output dmem_addr, input dmem_ack, input dmem_rdata);
   modport slave  (input dmem_req, input dmem_addr, output dmem_ack, output dmem_rdata);

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC candidate, jm read address and branch-register
// misalignment detect.
module next_pc_calc
   import flow_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      sel,
   input  logic            jbrn,
   input  logic [15:0]     imm16,
   input  logic [25:0]     jtarget,
   input  logic [XLEN-1:0] rs_val,
   output logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] jm_addr,
   output logic            misalign
);

   logic [XLEN-1:0] pc4;
   logic [XLEN-1:0] imm_sext;
   logic [XLEN-1:0] br_off;

   assign pc4      = pc + 32'd4;
   assign imm_sext = {{16{imm16[15]}}, imm16};
   assign br_off   = {imm_sext[29:0], 2'b00};
   assign jm_addr  = rs_val + imm_sext;

   always_comb begin
      next_pc  = pc4;
      misalign = 1'b0;
      case (sel)
         SEL_SEQ: next_pc = pc4;
         SEL_JMP: begin
            if (jbrn) begin
               next_pc  = {rs_val[31:2], 2'b00};
               misalign = (rs_val[1:0] != 2'b00);
            end else begin
               next_pc = {pc4[31:28], jtarget, 2'b00};
            end
         end
         SEL_BR:  next_pc = pc4 + br_off;
         default: next_pc = pc;   // jm resolves later through memory
      endcase
   end

endmodule

// File: rtl/next_pc_unit.sv
// Program-flow stage: PC and {Z,N} status registers plus the multi-cycle
// memory-indirect jump sequencer with ack timeout.
module next_pc_unit
   import flow_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned JM_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            advance,
   input  logic [1:0]      sel,
   input  logic            jbrn,
   input  logic [15:0]     imm16,
   input  logic [25:0]     jtarget,
   input  logic [XLEN-1:0] rs_val,
   input  logic            alu_z,
   input  logic            alu_n,
   input  logic            flag_we,
   next_pc_unit_if.master  dmem,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] link_addr,
   output logic [1:0]      stat,
   output logic            busy,
   output logic            jm_err
);

   localparam int unsigned CNT_W = $clog2(JM_TIMEOUT);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [1:0]      stat_q, stat_d;
   logic            busy_q, busy_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [XLEN-1:0] cand_pc;
   logic [XLEN-1:0] jm_addr;
   logic            misalign;

   next_pc_calc u_calc (
      .pc       (pc_q),
      .sel      (sel),
      .jbrn     (jbrn),
      .imm16    (imm16),
      .jtarget  (jtarget),
      .rs_val   (rs_val),
      .next_pc  (cand_pc),
      .jm_addr  (jm_addr),
      .misalign (misalign)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         stat_q  <= 2'b00;
         busy_q  <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         stat_q  <= stat_d;
         busy_q  <= busy_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      stat_d  = stat_q;
      busy_d  = busy_q;
      req_d   = req_q;
      addr_d  = addr_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (advance) begin
               if (flag_we) begin
                  stat_d[STAT_Z] = alu_z;
                  stat_d[STAT_N] = alu_n;
               end
               if (sel == SEL_JM) begin
                  state_d = JM_WAIT;
                  busy_d  = 1'b1;
                  req_d   = 1'b1;
                  addr_d  = jm_addr;
               end else begin
                  pc_d = cand_pc;
                  if (misalign) err_d = 1'b1;
               end
            end
         end
         JM_WAIT: begin
            // ack takes priority over the timeout abort on the same cycle
            if (dmem.dmem_ack) begin
               pc_d    = {dmem.dmem_rdata[31:2], 2'b00};
               if (dmem.dmem_rdata[1:0] != 2'b00) err_d = 1'b1;
               state_d = IDLE;
               busy_d  = 1'b0;
               req_d   = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(JM_TIMEOUT - 1)) begin
               pc_d    = pc_q + 32'd4;
               err_d   = 1'b1;
               state_d = IDLE;
               busy_d  = 1'b0;
               req_d   = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pc             = pc_q;
   assign link_addr      = pc_q + 32'd4;
   assign stat           = stat_q;
   assign busy           = busy_q;
   assign jm_err         = err_q;
   assign dmem.dmem_req  = req_q;
   assign dmem.dmem_addr = addr_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: sequential/branch/jump updates, jm handshake,
// timeout abort, status capture and asynchronous reset.
module tb_next_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        advance;
   logic [1:0]  sel;
   logic        jbrn;
   logic [15:0] imm16;
   logic [25:0] jtarget;
   logic [31:0] rs_val;
   logic        alu_z, alu_n, flag_we;
   logic [31:0] pc, link_addr;
   logic [1:0]  stat;
   logic        busy, jm_err;

   int n_cmp = 0;
   int n_err = 0;

   next_pc_unit_if dif ();

   next_pc_unit #(.RESET_PC(32'h0000_0000), .JM_TIMEOUT(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .advance   (advance),
      .sel       (sel),
      .jbrn      (jbrn),
      .imm16     (imm16),
      .jtarget   (jtarget),
      .rs_val    (rs_val),
      .alu_z     (alu_z),
      .alu_n     (alu_n),
      .flag_we   (flag_we),
      .dmem      (dif),
      .pc        (pc),
      .link_addr (link_addr),
      .stat      (stat),
      .busy      (busy),
      .jm_err    (jm_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      advance = 1'b0;
      step();
      reset   = 1'b0;
   endtask

   initial begin
      int cyc;
      reset = 1'b1; advance = 1'b0; sel = 2'b00; jbrn = 1'b0; imm16 = '0;
      jtarget = '0; rs_val = '0; alu_z = 1'b0; alu_n = 1'b0; flag_we = 1'b0;
      dif.dmem_ack = 1'b0; dif.dmem_rdata = '0;
      step(); step();
      reset = 1'b0;
      chk("rst_pc", pc, 32'h0);
      chk("rst_stat", 32'(stat), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_req", 32'(dif.dmem_req), 32'h0);
      chk("rst_err", 32'(jm_err), 32'h0);

      // 1: build up state, then reset asynchronously mid-jm
      advance = 1'b1; sel = 2'b00; flag_we = 1'b1; alu_z = 1'b1; alu_n = 1'b1;
      step();
      flag_we = 1'b0;
      chk("seq_pc4", pc, 32'h4);
      chk("flag_11", 32'(stat), 32'h3);
      sel = 2'b10; rs_val = 32'h40; imm16 = 16'h0;
      step();
      advance = 1'b0;
      chk("jm_busy", 32'(busy), 32'h1);
      chk("jm_hold_pc", pc, 32'h4);
      #2 reset = 1'b1;
      #1;
      chk("async_pc", pc, 32'h0);
      chk("async_stat", 32'(stat), 32'h0);
      chk("async_busy", 32'(busy), 32'h0);
      chk("async_req", 32'(dif.dmem_req), 32'h0);
      reset = 1'b0;
      dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h700;
      step();
      dif.dmem_ack = 1'b0;
      chk("late_ack_pc", pc, 32'h0);
      advance = 1'b1; sel = 2'b00;
      step(); chk("seq_a", pc, 32'h4);
      step(); chk("seq_b", pc, 32'h8);
      step(); chk("seq_c", pc, 32'hC);

      // 2: PC-relative branches from 0x100
      sel = 2'b01; jbrn = 1'b1; rs_val = 32'h100;
      step(); chk("brn_100", pc, 32'h100);
      chk("brn_noerr", 32'(jm_err), 32'h0);
      sel = 2'b11; imm16 = 16'hFFFF;
      step(); chk("br_neg", pc, 32'h100);
      imm16 = 16'h0003;
      step(); chk("br_pos", pc, 32'h110);
      advance = 1'b0;
      #1 chk("link", link_addr, 32'h114);

      // 3: J-format and misaligned register target
      advance = 1'b1; sel = 2'b01; jbrn = 1'b1; rs_val = 32'h4000_0010;
      step(); chk("brn_4k", pc, 32'h4000_0010);
      jbrn = 1'b0; jtarget = 26'h0000040;
      step(); chk("jfmt", pc, 32'h4000_0100);
      chk("jfmt_noerr", 32'(jm_err), 32'h0);
      jbrn = 1'b1; rs_val = 32'h2002;
      step(); chk("brn_mis_pc", pc, 32'h2000);
      chk("brn_mis_err", 32'(jm_err), 32'h1);
      do_reset();
      chk("err_cleared", 32'(jm_err), 32'h0);

      // 4: jm with ack on third wait cycle, advance pulses ignored
      advance = 1'b1; sel = 2'b10; rs_val = 32'h80; imm16 = 16'h0004;
      step();
      sel = 2'b00;
      chk("jm_addr", dif.dmem_addr, 32'h84);
      chk("jm_req", 32'(dif.dmem_req), 32'h1);
      step();
      chk("jm_busy2", 32'(busy), 32'h1);
      chk("jm_pc_held", pc, 32'h0);
      advance = 1'b0;
      step();
      advance = 1'b1;
      chk("jm_busy3", 32'(busy), 32'h1);
      dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h500;
      step();
      dif.dmem_ack = 1'b0; advance = 1'b0;
      chk("jm_pc", pc, 32'h500);
      chk("jm_done_busy", 32'(busy), 32'h0);
      chk("jm_done_req", 32'(dif.dmem_req), 32'h0);
      chk("jm_noerr", 32'(jm_err), 32'h0);
      step(); chk("idle_hold", pc, 32'h500);

      // 5: timeout abort
      advance = 1'b1; sel = 2'b10; rs_val = 32'h1000; imm16 = 16'hFFFC;
      step();
      advance = 1'b0;
      chk("to_addr", dif.dmem_addr, 32'hFFC);
      cyc = 1;
      while (busy && cyc < 40) begin
         step();
         if (busy) cyc++;
      end
      chk("to_len", 32'(cyc), 32'd16);
      chk("to_pc", pc, 32'h504);
      chk("to_err", 32'(jm_err), 32'h1);

      // ack on the timeout cycle beats the abort
      do_reset();
      advance = 1'b1; sel = 2'b10; rs_val = 32'h0; imm16 = 16'h0;
      step();
      advance = 1'b0;
      repeat (15) step();
      chk("to_edge_busy", 32'(busy), 32'h1);
      dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h900;
      step();
      dif.dmem_ack = 1'b0;
      chk("to_ack_pc", pc, 32'h900);
      chk("to_ack_err", 32'(jm_err), 32'h0);

      // first-cycle ack with misaligned memory target
      advance = 1'b1;
      step();
      advance = 1'b0;
      dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h0A02;
      step();
      dif.dmem_ack = 1'b0;
      chk("jm_mis_pc", pc, 32'hA00);
      chk("jm_mis_err", 32'(jm_err), 32'h1);
      chk("jm_mis_busy", 32'(busy), 32'h0);

      // 6: status capture and PC wrap
      do_reset();
      advance = 1'b1; sel = 2'b00; flag_we = 1'b1; alu_z = 1'b1; alu_n = 1'b0;
      step(); chk("flag_10", 32'(stat), 32'h2);
      advance = 1'b0; alu_z = 1'b0; alu_n = 1'b1;
      step(); chk("flag_noadv", 32'(stat), 32'h2);
      flag_we = 1'b0;
      advance = 1'b1; sel = 2'b01; jbrn = 1'b1; rs_val = 32'hFFFF_FFFC;
      step(); chk("pc_top", pc, 32'hFFFF_FFFC);
      chk("link_wrap", link_addr, 32'h0);
      sel = 2'b00;
      step(); chk("pc_wrap", pc, 32'h0);
      advance = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
